// File: rtl/fm_tile_feeder.sv
// fm_tile_feeder: packs raster pixels into beats and hands each beat to the engine map input.
// Optional FEED_STALL_CNT_EN adds the stall_cycles counter port.
module fm_tile_feeder #(
  parameter int IMG_WIDTH = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int PIX_W = 8,
  parameter int BEAT_W = 128
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [BEAT_W-1:0] map_out,
  output logic              start,
  input  logic              engine_ready,
  output logic              last_beat,
  output logic [15:0]       beat_idx,
  output logic              frame_done
`ifdef FEED_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int PIX_PER_BEAT = BEAT_W / PIX_W;
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int NBEATS = (NPIX + PIX_PER_BEAT - 1) / PIX_PER_BEAT;
  localparam int LW = $clog2(PIX_PER_BEAT + 1);
  localparam int CW = $clog2(NPIX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;
  state_t state;
  logic [BEAT_W-1:0] pack, hold;
  logic [LW-1:0] lane;
  logic [CW-1:0] pix_cnt;
  logic hold_full, pack_done, take, fire;
  // a partially filled pack is closed once the frame's last pixel is in
  assign pack_done = lane == LW'(PIX_PER_BEAT) || (lane != '0 && pix_cnt == CW'(NPIX));
  assign pix_ready = rst_in && !pack_done && pix_cnt < CW'(NPIX);
  assign take = pix_valid && pix_ready;
  assign fire = (state == IDLE || state == ISSUE) && hold_full && engine_ready;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      pack <= '0;
      hold <= '0;
      lane <= '0;
      pix_cnt <= '0;
      hold_full <= 1'b0;
      map_out <= '0;
      start <= 1'b0;
      last_beat <= 1'b0;
      beat_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      start <= fire;
      frame_done <= 1'b0;
      if (take) begin
        pack[PIX_W*lane +: PIX_W] <= pix_in;
        lane <= lane + 1'b1;
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (pack_done && !hold_full) begin
        hold <= pack;
        hold_full <= 1'b1;
        pack <= '0;
        lane <= '0;
      end
      // hold is released as the beat is issued so the next beat can move in during compute
      case (state)
        IDLE, ISSUE:
          if (fire) begin
            map_out <= hold;
            hold_full <= 1'b0;
            last_beat <= beat_idx == 16'(NBEATS - 1);
            state <= WAIT_LO;
          end else state <= hold_full ? ISSUE : IDLE;
        WAIT_LO: if (!engine_ready) state <= WAIT_HI;
        WAIT_HI:
          if (engine_ready) begin
            if (last_beat) begin
              frame_done <= 1'b1;
              beat_idx <= '0;
              pix_cnt <= '0;
              last_beat <= 1'b0;
              state <= IDLE;
            end else begin
              beat_idx <= beat_idx + 1'b1;
              state <= hold_full ? ISSUE : IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FEED_STALL_CNT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) stall_cycles <= '0;
    else if (frame_done) stall_cycles <= '0;
    else if (hold_full && !fire && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end
`endif
endmodule
